// File: rtl/word_serializer_if.sv
// word_serializer_if
//
// Bundles the parallel word handshake and the serial output line of the
// word serializer so the producer, the serializer and a bench can share
// one connection.
//
//   in_valid  producer offers the word on `in`
//   in        parallel word (DATA_WIDTH bits)
//   in_ready  serializer accepts `in` this cycle
//   ser_out   current serial bit
//   ser_valid ser_out carries a valid bit
//   ser_last  final bit of a word is on ser_out
//   busy      a word is in flight
//
// The slave modport is the serializer's view; the master modport is the
// producer/consumer side.
interface word_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in;
    logic                  in_ready;
    logic                  ser_out;
    logic                  ser_valid;
    logic                  ser_last;
    logic                  busy;

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );
endinterface

// File: rtl/word_serializer.sv
// word_serializer
//
// Parallel-to-serial transmitter. A DATA_WIDTH-bit word is taken through a
// valid/ready handshake and shifted out one bit at a time, each bit held
// for BIT_CYCLES clocks. A new word can be accepted on the final cycle of
// the current one, so words stream with no idle gap.
//
//   clk    system clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   flush  synchronous abort of the word in flight
//   bus    word_serializer_if.slave: in_valid/in/in_ready handshake and
//          ser_out/ser_valid/ser_last/busy serial outputs
module word_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    word_serializer_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  ser_last_q, ser_last_d;

    logic                  final_cycle;
    logic                  in_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sh_shifted;
    logic                  in_end_bit;
    logic [BW-1:0]         bit_cnt_inc;

    // The last clock of the last bit of a word; the only SHIFT cycle in
    // which the next word may be taken.
    assign final_cycle = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT) &&
                         (cyc_cnt_q == LAST_CYC);

    // Ready depends only on state, rst and flush, never on in_valid.
    assign in_ready = !rst && !flush && ((state_q == IDLE) || final_cycle);
    assign accept   = bus.in_valid && in_ready;

    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    // Move the word one place toward the output end, zero-filling behind,
    // and pick the bit that sits at the output end of an incoming word.
    always_comb begin
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[DATA_WIDTH-2:0], 1'b0};
            in_end_bit = bus.in[DATA_WIDTH-1];
        end else begin
            sh_shifted = {1'b0, sh_q[DATA_WIDTH-1:1]};
            in_end_bit = bus.in[0];
        end
    end

    // Next-state logic: flush beats accept, accept beats shifting.
    // rst is handled in the register process and beats everything.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;

        if (flush) begin
            state_d     = IDLE;
            sh_d        = '0;
            bit_cnt_d   = '0;
            cyc_cnt_d   = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
        end else if (accept) begin
            state_d     = SHIFT;
            sh_d        = bus.in;
            bit_cnt_d   = '0;
            cyc_cnt_d   = '0;
            ser_out_d   = in_end_bit;
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (final_cycle) begin
                state_d     = IDLE;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                ser_last_d  = 1'b0;
            end else if (cyc_cnt_q != LAST_CYC) begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end else begin
                cyc_cnt_d  = '0;
                bit_cnt_d  = bit_cnt_inc;
                sh_d       = sh_shifted;
                ser_out_d  = MSB_FIRST ? sh_shifted[DATA_WIDTH-1] : sh_shifted[0];
                ser_last_d = (bit_cnt_inc == LAST_BIT);
            end
        end else begin
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.busy      = (state_q == SHIFT);
endmodule
